// File: rtl/add_sched_pkg.sv
// Shared defaults and helpers for the add-pipe issue scheduler.
package add_sched_pkg;

  localparam int WIDTH_D = 32;
  localparam int NREQ_D  = 4;
  localparam int RDW_D   = 5;
  localparam int LAT_D   = 3;

  // Round-robin successor of a requester index, wrapping at n.
  function automatic int rr_next(input int idx, input int n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational rotating-priority arbiter: the first eligible requester at or
// after ptr (circularly) wins. The pointer register lives in the parent.
module rr_arbiter #(
  parameter int NREQ = 4,
  parameter int SRCW = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req_elig,
  input  logic [SRCW-1:0] ptr,
  output logic [NREQ-1:0] gnt,
  output logic [SRCW-1:0] gnt_idx,
  output logic            gnt_any
);

  // Circular scan starting at ptr; only the first hit is granted
  always_comb begin
    int idx;
    // NOTE: every output gets a default before the loop so no path leaves a
    // value unassigned; otherwise synthesis infers a latch.
    gnt     = '0;
    gnt_idx = '0;
    gnt_any = 1'b0;
    idx     = 0;
    for (int k = 0; k < NREQ; k++) begin
      idx = int'(ptr) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      if (!gnt_any && req_elig[idx]) begin
        gnt[idx] = 1'b1;
        gnt_idx  = SRCW'(idx);
        gnt_any  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/add_issue_sched.sv
// Issue scheduler sharing one external pipelined adder between NREQ requesters.
// Round-robin grant, one issue per cycle, a per-destination busy scoreboard to
// block read-after-write hazards, and a LAT-deep tracker that tags each op so
// its result returns as {rd, sum, src} on the writeback port.
module add_issue_sched
  import add_sched_pkg::*;
#(
  parameter int WIDTH = WIDTH_D,
  parameter int NREQ  = NREQ_D,
  parameter int RDW   = RDW_D,
  parameter int LAT   = LAT_D,
  parameter int SRCW  = $clog2(NREQ)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req,
  input  logic [NREQ*WIDTH-1:0] req_a,
  input  logic [NREQ*WIDTH-1:0] req_b,
  input  logic [NREQ*RDW-1:0]  req_rd,
  input  logic                 hold,
  output logic [NREQ-1:0]      gnt,
  output logic [WIDTH-1:0]     pipe_a,
  output logic [WIDTH-1:0]     pipe_b,
  output logic                 pipe_start,
  output logic [RDW-1:0]       pipe_rd,
  input  logic [WIDTH-1:0]     pipe_sum,
  input  logic [RDW-1:0]       pipe_rdout,
  output logic                 wb_valid,
  output logic [WIDTH-1:0]     wb_data,
  output logic [RDW-1:0]       wb_rd,
  output logic [SRCW-1:0]      wb_src,
  output logic                 tag_err,
  output logic                 idle
);

  typedef struct packed {
    logic            v;
    logic [SRCW-1:0] src;
    logic [RDW-1:0]  rd;
  } trk_entry_t;

  logic [NREQ-1:0]    elig;
  logic [SRCW-1:0]    gnt_idx;
  logic               gnt_any;
  logic [SRCW-1:0]    rr_ptr;
  logic [SRCW-1:0]    pipe_src;
  logic [2**RDW-1:0]  busy;
  trk_entry_t         trk [LAT];
  trk_entry_t         tail;
  logic               trk_any;
  logic [WIDTH-1:0]   sel_a;
  logic [WIDTH-1:0]   sel_b;
  logic [RDW-1:0]     sel_rd;

  // A requester is eligible when pending, its destination is not in flight,
  // issue is not held off, and the block is not in reset
  always_comb begin
    elig = '0;
    for (int i = 0; i < NREQ; i++)
      elig[i] = req[i] & ~busy[req_rd[i*RDW +: RDW]] & ~hold & ~rst;
  end

  rr_arbiter #(
    .NREQ (NREQ),
    .SRCW (SRCW)
  ) u_arb (
    .req_elig (elig),
    .ptr      (rr_ptr),
    .gnt      (gnt),
    .gnt_idx  (gnt_idx),
    .gnt_any  (gnt_any)
  );

  // Operand/destination of the winning requester
  always_comb begin
    sel_a  = req_a[int'(gnt_idx)*WIDTH +: WIDTH];
    sel_b  = req_b[int'(gnt_idx)*WIDTH +: WIDTH];
    sel_rd = req_rd[int'(gnt_idx)*RDW +: RDW];
  end

  // Issue registers: launch the granted op into the adder, advance rr pointer
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pipe_a     <= '0;
      pipe_b     <= '0;
      pipe_rd    <= '0;
      pipe_src   <= '0;
      pipe_start <= 1'b0;
      rr_ptr     <= '0;
    end else begin
      // NOTE: state is updated with non-blocking assignments so every flop
      // samples pre-edge values, independent of statement order.
      pipe_start <= gnt_any;
      if (gnt_any) begin
        pipe_a   <= sel_a;
        pipe_b   <= sel_b;
        pipe_rd  <= sel_rd;
        pipe_src <= gnt_idx;
        rr_ptr   <= SRCW'(rr_next(int'(gnt_idx), NREQ));
      end
    end
  end

  // Busy scoreboard: set on grant, cleared when the op writes back. A clear
  // and a set never target the same rd in one cycle because a busy rd is
  // ineligible for the whole cycle in which it clears.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: this register file is reset, unlike a datapath RAM, because a
      // stale busy bit would block its destination forever.
      busy <= '0;
    end else begin
      if (tail.v)  busy[tail.rd] <= 1'b0;
      if (gnt_any) busy[sel_rd]  <= 1'b1;
    end
  end

  // Tracker shift register follows each op through the adder's latency
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int s = 0; s < LAT; s++) trk[s] <= '0;
    end else begin
      trk[0] <= '{v: pipe_start, src: pipe_src, rd: pipe_rd};
      for (int s = 1; s < LAT; s++) trk[s] <= trk[s-1];
    end
  end

  // Any op still travelling through the tracker
  always_comb begin
    trk_any = 1'b0;
    for (int s = 0; s < LAT; s++) trk_any = trk_any | trk[s].v;
  end

  // Sticky flag: adder returned a different tag than the one we tracked
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                              tag_err <= 1'b0;
    else if (tail.v && pipe_rdout != tail.rd) tag_err <= 1'b1;
  end

  assign tail     = trk[LAT-1];
  assign wb_valid = tail.v;
  assign wb_rd    = tail.rd;
  assign wb_src   = tail.src;
  assign wb_data  = pipe_sum;
  assign idle     = ~trk_any & ~pipe_start & ~(|req);

endmodule

// File: tb/tb_add_issue_sched.sv
// Self-checking bench for add_issue_sched with a behavioural LAT-stage adder.
// A queue-based model predicts grants, issue registers and writebacks every
// cycle; directed scenarios add hand-computed literal expectations.
module tb_add_issue_sched;

  localparam int WIDTH = 32;
  localparam int NREQ  = 4;
  localparam int RDW   = 5;
  localparam int LAT   = 3;
  localparam int SRCW  = 2;

  logic                  clk = 1'b0;
  logic                  rst = 1'b0;
  logic [NREQ-1:0]       req;
  logic [NREQ*WIDTH-1:0] req_a;
  logic [NREQ*WIDTH-1:0] req_b;
  logic [NREQ*RDW-1:0]   req_rd;
  logic                  hold;
  logic [NREQ-1:0]       gnt;
  logic [WIDTH-1:0]      pipe_a;
  logic [WIDTH-1:0]      pipe_b;
  logic                  pipe_start;
  logic [RDW-1:0]        pipe_rd;
  logic [WIDTH-1:0]      pipe_sum;
  logic [RDW-1:0]        pipe_rdout;
  logic                  wb_valid;
  logic [WIDTH-1:0]      wb_data;
  logic [RDW-1:0]        wb_rd;
  logic [SRCW-1:0]       wb_src;
  logic                  tag_err;
  logic                  idle;

  always #5 clk = ~clk;

  add_issue_sched #(
    .WIDTH (WIDTH), .NREQ (NREQ), .RDW (RDW), .LAT (LAT)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req        (req),
    .req_a      (req_a),
    .req_b      (req_b),
    .req_rd     (req_rd),
    .hold       (hold),
    .gnt        (gnt),
    .pipe_a     (pipe_a),
    .pipe_b     (pipe_b),
    .pipe_start (pipe_start),
    .pipe_rd    (pipe_rd),
    .pipe_sum   (pipe_sum),
    .pipe_rdout (pipe_rdout),
    .wb_valid   (wb_valid),
    .wb_data    (wb_data),
    .wb_rd      (wb_rd),
    .wb_src     (wb_src),
    .tag_err    (tag_err),
    .idle       (idle)
  );

  // Behavioural add_pipe: sum and tag emerge LAT cycles after being presented
  logic [WIDTH-1:0] ap_sum [LAT];
  logic [RDW-1:0]   ap_rd  [LAT];
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int s = 0; s < LAT; s++) begin ap_sum[s] <= '0; ap_rd[s] <= '0; end
    end else begin
      ap_sum[0] <= pipe_a + pipe_b;
      ap_rd[0]  <= pipe_rd;
      for (int s = 1; s < LAT; s++) begin ap_sum[s] <= ap_sum[s-1]; ap_rd[s] <= ap_rd[s-1]; end
    end
  end
  assign pipe_sum   = ap_sum[LAT-1];
  assign pipe_rdout = ap_rd[LAT-1];

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    int              due;
    logic [RDW-1:0]  rd;
    logic [SRCW-1:0] src;
    logic [WIDTH-1:0] sum;
  } op_t;

  op_t              q[$];
  logic [31:0]      busy_m;
  int               rr_m;
  logic             m_start;
  logic [WIDTH-1:0] m_a, m_b;
  logic [RDW-1:0]   m_rd;
  logic [NREQ-1:0]  gnt_seen;

  always @(negedge clk) begin
    logic [NREQ-1:0] exp_gnt;
    logic            exp_wb;
    logic [RDW-1:0]  rdi;
    int              win;
    int              i;
    gnt_seen = gnt;
    if (rst) begin
      q.delete();
      busy_m  = '0;
      rr_m    = 0;
      m_start = 1'b0;
      m_a     = '0;
      m_b     = '0;
      m_rd    = '0;
      check("rst_gnt", gnt, 0);
      check("rst_start", pipe_start, 0);
      check("rst_pipe_a", pipe_a, 0);
      check("rst_pipe_rd", pipe_rd, 0);
      check("rst_wb_valid", wb_valid, 0);
      check("rst_tag_err", tag_err, 0);
      check("rst_idle", idle, (req == '0));
    end else begin
      exp_gnt = '0;
      win = -1;
      if (!hold) begin
        for (int k = 0; k < NREQ; k++) begin
          i   = (rr_m + k) % NREQ;
          rdi = req_rd[i*RDW +: RDW];
          if (win < 0 && req[i] && !busy_m[rdi]) win = i;
        end
      end
      if (win >= 0) exp_gnt[win] = 1'b1;
      check("gnt", gnt, exp_gnt);
      check("pipe_start", pipe_start, m_start);
      check("pipe_a", pipe_a, m_a);
      check("pipe_b", pipe_b, m_b);
      check("pipe_rd", pipe_rd, m_rd);
      exp_wb = (q.size() > 0) && (q[0].due == cyc);
      check("wb_valid", wb_valid, exp_wb);
      if (exp_wb) begin
        check("wb_data", wb_data, q[0].sum);
        check("wb_rd", wb_rd, q[0].rd);
        check("wb_src", wb_src, q[0].src);
      end
      check("tag_err", tag_err, 0);
      check("idle", idle, (q.size() == 0) && (req == '0));
      // advance the model across the coming edge: retire first, then issue
      if (exp_wb) begin
        busy_m[q[0].rd] = 1'b0;
        void'(q.pop_front());
      end
      m_start = (win >= 0);
      if (win >= 0) begin
        m_a  = req_a[win*WIDTH +: WIDTH];
        m_b  = req_b[win*WIDTH +: WIDTH];
        m_rd = req_rd[win*RDW +: RDW];
        q.push_back('{cyc + 1 + LAT, m_rd, SRCW'(win), m_a + m_b});
        busy_m[m_rd] = 1'b1;
        rr_m = (win + 1) % NREQ;
      end
    end
    cyc++;
  end

  // ---------------- stimulus helpers ----------------
  task automatic set_op(input int i, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                        input logic [RDW-1:0] rd);
    req_a[i*WIDTH +: WIDTH] = a;
    req_b[i*WIDTH +: WIDTH] = b;
    req_rd[i*RDW +: RDW]    = rd;
    req[i]                  = 1'b1;
  endtask

  // Advance one cycle; requesters granted at that edge withdraw
  task automatic next_cycle();
    @(posedge clk);
    #1;
    for (int i = 0; i < NREQ; i++) if (gnt_seen[i]) req[i] = 1'b0;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst  = 1'b1;
    req  = '0;
    hold = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    next_cycle();
    while (idle !== 1'b1 && n < 40) begin
      next_cycle();
      n++;
    end
    @(negedge clk);
    check(name, idle, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    req    = '0;
    req_a  = '0;
    req_b  = '0;
    req_rd = '0;
    hold   = 1'b0;
    #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // 1. single op: 5 + 7 -> rd 3 from requester 0
    do_reset();
    set_op(0, 5, 7, 3);
    @(negedge clk); check("s1_gnt", gnt, 4'b0001);
    next_cycle();
    @(negedge clk); check("s1_start", pipe_start, 1); check("s1_pipe_a", pipe_a, 5);
    repeat (3) @(negedge clk);
    check("s1_wb_valid", wb_valid, 1);
    check("s1_wb_data", wb_data, 12);
    check("s1_wb_rd", wb_rd, 3);
    check("s1_wb_src", wb_src, 0);
    next_cycle();
    set_op(1, 1, 1, 3);
    @(negedge clk); check("s1_rd3_free", gnt, 4'b0010);
    drain("s1_idle");

    // 2. all four requesting, distinct rd 1..4, held
    do_reset();
    for (int i = 0; i < NREQ; i++) set_op(i, $urandom, $urandom, RDW'(i + 1));
    for (int k = 0; k < 4; k++) begin
      @(negedge clk); check("s2_gnt_seq", gnt, 1 << k);
      @(posedge clk); #1;
    end
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("s2_wb_valid", wb_valid, 1);
      check("s2_wb_src", wb_src, k);
      if (k == 0) check("s2_gnt_all_busy", gnt, 0);
      if (k == 1) check("s2_gnt_wrap", gnt, 4'b0001);
    end
    @(posedge clk); #1; req = '0;
    drain("s2_idle");

    // 3. two requesters on rd 9: the second waits for the first's writeback
    do_reset();
    set_op(0, 10, 20, 9);
    set_op(1, 30, 40, 9);
    @(negedge clk); check("s3_gnt0", gnt, 4'b0001);
    begin
      int n;
      n = 0;
      do begin
        next_cycle();
        n++;
        @(negedge clk);
      end while (gnt !== 4'b0010 && n < 20);
      check("s3_wait_cycles", n, 5);
    end
    drain("s3_idle");

    // 4. hold for three cycles, then grants resume from the pointer
    do_reset();
    hold = 1'b1;
    set_op(0, 1, 2, 10);
    set_op(1, 3, 4, 11);
    repeat (3) begin
      @(negedge clk);
      check("s4_hold_gnt", gnt, 0);
      check("s4_hold_start", pipe_start, 0);
      next_cycle();
    end
    hold = 1'b0;
    @(negedge clk); check("s4_resume0", gnt, 4'b0001);
    next_cycle();
    @(negedge clk); check("s4_resume1", gnt, 4'b0010);
    drain("s4_idle");

    // 5. reset one cycle after two grants: those ops never write back
    do_reset();
    set_op(0, 100, 1, 12);
    set_op(1, 200, 2, 13);
    @(negedge clk); check("s5_gnt0", gnt, 4'b0001);
    next_cycle();
    @(negedge clk); check("s5_gnt1", gnt, 4'b0010);
    next_cycle();
    rst = 1'b1;
    req = '0;
    @(posedge clk); #1; rst = 1'b0;
    for (int k = 0; k < LAT + 3; k++) begin
      @(negedge clk);
      check("s5_no_wb", wb_valid, 0);
      check("s5_idle", idle, 1);
    end
    @(posedge clk); #1;
    set_op(2, 7, 8, 12);
    @(negedge clk); check("s5_gnt2", gnt, 4'b0100);
    drain("s5_drain");

    // 6. wraparound: all-ones + 1 = 0
    do_reset();
    set_op(0, 32'hFFFF_FFFF, 1, 0);
    @(negedge clk); check("s6_gnt", gnt, 4'b0001);
    next_cycle();
    @(negedge clk);
    repeat (3) @(negedge clk);
    check("s6_wb_valid", wb_valid, 1);
    check("s6_wb_data", wb_data, 0);
    drain("s6_idle");

    // Random traffic with rd conflicts, hold and occasional reset
    do_reset();
    for (int c = 0; c < 600; c++) begin
      next_cycle();
      for (int i = 0; i < NREQ; i++)
        if (!req[i] && $urandom_range(0, 2) == 0)
          set_op(i, $urandom, $urandom, RDW'($urandom_range(0, 7)));
      hold = ($urandom_range(0, 9) == 0);
      if ($urandom_range(0, 199) == 0) begin
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
      end
    end
    hold = 1'b0;
    drain("rand_idle");
    check("final_tag_err", tag_err, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
